// File: rtl/niosqsys_mem_stream_loader.sv
// Packs an incoming byte stream little-endian into 32-bit words and writes them
// to consecutive word addresses of a single-port on-chip RAM.
module niosqsys_mem_stream_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    localparam logic [CNT_W-1:0] MaxBytes = CNT_W'(4 * (2 ** ADDR_W));

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic              wrapped_q, wrapped_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rem_q     <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            be_q      <= be_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        lane_d    = lane_q;
        data_d    = data_q;
        be_d      = be_q;
        wrapped_d = wrapped_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = base_addr;
                    rem_d     = (byte_count > MaxBytes) ? MaxBytes : byte_count;
                    lane_d    = '0;
                    data_d    = '0;
                    be_d      = '0;
                    wrapped_d = 1'b0;
                    state_d   = (byte_count == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (in_valid) begin
                    data_d[8*lane_q +: 8] = in_data;
                    be_d[lane_q]          = 1'b1;
                    lane_d                = lane_q + 2'd1;
                    rem_d                 = rem_q - 1'b1;
                    // Flush on a full word or on the last byte of the load
                    if (lane_q == 2'd3 || rem_q == CNT_W'(1)) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d = addr_q + 1'b1;
                if (&addr_q) begin
                    wrapped_d = 1'b1;
                end
                lane_d  = '0;
                data_d  = '0;
                be_d    = '0;
                state_d = (rem_q == '0) ? StDone : StFill;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready       = (state_q == StFill);
        mem_address    = addr_q;
        mem_chipselect = (state_q == StWrite);
        mem_write      = (state_q == StWrite);
        mem_byteenable = (state_q == StWrite) ? be_q : 4'b0000;
        mem_writedata  = (state_q == StWrite) ? data_q : 32'h0;
        mem_clken      = 1'b1;
        busy           = (state_q != StIdle);
        done           = (state_q == StDone);
        wrapped        = wrapped_q;
    end

endmodule
